// File: rtl/gate_tt_checker_if.sv
// Connection between the truth-table checker and a 2-input gate under test.
// The checker drives the stimulus A/B and observes the gate output C.
interface gate_tt_checker_if;
  logic A;
  logic B;
  logic C;

  modport master (output A, output B, input C);
  modport slave  (input A, input B, output C);
endinterface

// File: rtl/gate_tt_checker.sv
// Self-running truth-table checker for a 2-input gate. It walks {A,B} through
// 00..11, holds each vector SETTLE extra cycles, captures C and compares the result with EXPECTED.
module gate_tt_checker #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [3:0]  EXPECTED = 4'b0111
) (
  input  logic                      clk,
  input  logic                      rst_n,
  gate_tt_checker_if.master         gut,
  input  logic                      start_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [3:0]                result_tt_o,
  output logic [3:0]                fail_mask_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Last settle-count value before SAMPLE; unused when SETTLE is zero.
  localparam logic [7:0] SETTLE_LAST = (SETTLE == 32'd0) ? 8'd0 : 8'(SETTLE - 32'd1);
  localparam state_e     VEC_STATE   = (SETTLE == 32'd0) ? SAMPLE : DRIVE;

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] result_q, result_d;
  logic [3:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state and result bookkeeping for the run sequencer.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          vec_d    = 2'd0;
          cnt_d    = 8'd0;
          result_d = 4'd0;
          fail_d   = 4'd0;
          pass_d   = 1'b0;
          state_d  = VEC_STATE;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        if (abort_i) begin
          state_d  = IDLE;
          vec_d    = 2'd0;
          cnt_d    = 8'd0;
          result_d = 4'd0;
          fail_d   = 4'd0;
          pass_d   = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 8'd0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        if (abort_i) begin
          state_d  = IDLE;
          vec_d    = 2'd0;
          cnt_d    = 8'd0;
          result_d = 4'd0;
          fail_d   = 4'd0;
          pass_d   = 1'b0;
        end else begin
          result_d[vec_q] = gut.C;
          // The last capture feeds the verdict directly so it is ready in the DONE cycle.
          if (vec_q == 2'd3) begin
            state_d = DONE;
            fail_d  = result_d ^ EXPECTED;
            pass_d  = (result_d == EXPECTED);
          end else begin
            vec_d   = vec_q + 2'd1;
            state_d = VEC_STATE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        vec_d   = 2'd0;
      end
      default: begin
        state_d = IDLE;
        vec_d   = 2'd0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Registered-output values derived from the upcoming state.
  always_comb begin
    ab_d   = 2'd0;
    busy_d = 1'b0;
    done_d = 1'b0;
    if ((state_d == DRIVE) || (state_d == SAMPLE)) begin
      ab_d   = vec_d;
      busy_d = 1'b1;
    end else begin
      ab_d   = 2'd0;
      busy_d = 1'b0;
    end
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= 2'd0;
      cnt_q    <= 8'd0;
      result_q <= 4'd0;
      fail_q   <= 4'd0;
      pass_q   <= 1'b0;
      ab_q     <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
      ab_q     <= ab_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign gut.A       = ab_q[1];
  assign gut.B       = ab_q[0];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign result_tt_o = result_q;
  assign fail_mask_o = fail_q;

endmodule
